// File: rtl/seg_pkg.sv
// Shared constants for the 4-digit multiplexed 7-segment scan driver.
// Segment vectors are active-low and ordered {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  // Entry 15 is listed first so that HEX_SEG[h] returns the glyph for h.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,   // F E d C
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,   // b A 9 8
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,   // 7 6 5 4
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000    // 3 2 1 0
  };

  typedef struct packed {
    logic [3:0][3:0] digit;
    logic [3:0]      blank;
    logic [3:0]      dpm;
  } frame_t;

  localparam frame_t FRAME_RESET = '{digit: '0, blank: 4'b1111, dpm: 4'b0000};

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex digit to active-low 7-segment glyph lookup.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[hex];

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed 7-segment driver with double-buffered frame data,
// frame-aligned commit and a 3-bit PWM brightness control.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] blank_mask,
  input  logic [3:0] dp_mask,
  input  logic [2:0] bright,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       frame_done
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic [2:0]    pwm_cnt;
  logic          pending;
  logic          frame_wrap_q;
  frame_t        shadow;
  frame_t        active;

  logic          slot_wrap;
  logic          frame_wrap;
  logic          lit;
  logic [3:0]    cur_digit;
  logic [6:0]    dec_seg;

  assign slot_wrap  = (presc == PW'(SCAN_DIV - 1));
  assign frame_wrap = slot_wrap && (idx == 2'd3);
  assign cur_digit  = active.digit[idx];
  assign lit        = (pwm_cnt <= bright) && !active.blank[idx];

  seg_hex_decode u_hex_decode (
    .hex (cur_digit),
    .seg (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      presc        <= '0;
      idx          <= '0;
      pwm_cnt      <= '0;
      pending      <= 1'b0;
      shadow       <= FRAME_RESET;
      active       <= FRAME_RESET;
      frame_wrap_q <= 1'b0;
      frame_done   <= 1'b0;
      seg          <= SEG_BLANK;
      an           <= AN_OFF;
      dp           <= 1'b1;
    end else begin
      presc   <= slot_wrap ? '0 : presc + 1'b1;
      pwm_cnt <= pwm_cnt + 1'b1;
      if (slot_wrap) idx <= idx + 1'b1;

      // A load landing on the wrap commits the old shadow and stays pending.
      if (frame_wrap && pending) active <= shadow;
      if (load) begin
        shadow.digit <= {d3, d2, d1, d0};
        shadow.blank <= blank_mask;
        shadow.dpm   <= dp_mask;
        pending      <= 1'b1;
      end else if (frame_wrap) begin
        pending <= 1'b0;
      end

      // Delayed one extra stage so the pulse lines up with the first
      // registered output cycle of slot 0.
      frame_wrap_q <= frame_wrap;
      frame_done   <= frame_wrap_q;

      if (lit) begin
        an  <= ~(4'b0001 << idx);
        seg <= dec_seg;
        dp  <= ~active.dpm[idx];
      end else begin
        an  <= AN_OFF;
        seg <= SEG_BLANK;
        dp  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: cycle-level reference model of the
// scan/commit/PWM rules plus directed scenarios and randomized traffic.
module tb_seg_scan_driver;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  localparam logic [3:0] AN_SEQ  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  localparam logic [6:0] SEG_SEQ [4] = '{7'b1000000, 7'b1111001, 7'b0000000, 7'b0001110};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [3:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
  logic [3:0] blank_mask = '0, dp_mask = '0;
  logic [2:0] bright = 3'd7;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       frame_done;

  always #5 clk = ~clk;

  seg_scan_driver #(.SCAN_DIV(DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .d0         (d0),
    .d1         (d1),
    .d2         (d2),
    .d3         (d3),
    .blank_mask (blank_mask),
    .dp_mask    (dp_mask),
    .bright     (bright),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Reference state: k = clock edges since reset released.
  int         k;
  logic [3:0] sh_d  [4];
  logic [3:0] act_d [4];
  logic [3:0] sh_blank, act_blank, sh_dp, act_dp;
  bit         pend;
  bit         lit_seen;

  function automatic logic [6:0] font(input logic [3:0] h);
    case (h)
      4'h0: font = 7'b1000000;  4'h1: font = 7'b1111001;
      4'h2: font = 7'b0100100;  4'h3: font = 7'b0110000;
      4'h4: font = 7'b0011001;  4'h5: font = 7'b0010010;
      4'h6: font = 7'b0000010;  4'h7: font = 7'b1111000;
      4'h8: font = 7'b0000000;  4'h9: font = 7'b0010000;
      4'hA: font = 7'b0001000;  4'hB: font = 7'b0000011;
      4'hC: font = 7'b1000110;  4'hD: font = 7'b0100001;
      4'hE: font = 7'b0000110;  default: font = 7'b0001110;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    k = 0;
    pend = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sh_d[i]  = '0;
      act_d[i] = '0;
    end
    sh_blank  = 4'hF;
    act_blank = 4'hF;
    sh_dp     = '0;
    act_dp    = '0;
  endtask

  task automatic tick();
    logic [6:0] e_seg;
    logic       e_dp;
    logic [3:0] e_an;
    logic       e_fd;
    int         slot;
    bit         at_wrap;
    slot    = (k / DIV) % 4;
    at_wrap = (k % FRAME) == FRAME - 1;
    e_seg = 7'b1111111;
    e_dp  = 1'b1;
    e_an  = 4'b1111;
    e_fd  = 1'b0;
    if (!rst) begin
      e_fd = (k > 0) && (k % FRAME == 0);
      if (int'(k % 8) <= int'(bright) && !act_blank[slot]) begin
        e_an  = ~(4'b0001 << slot);
        e_seg = font(act_d[slot]);
        e_dp  = ~act_dp[slot];
      end
    end
    @(posedge clk);
    #1;
    check("seg", 32'(seg), 32'(e_seg));
    check("dp", 32'(dp), 32'(e_dp));
    check("an", 32'(an), 32'(e_an));
    check("frame_done", 32'(frame_done), 32'(e_fd));
    check("an_onehot", 32'($countones(~an) <= 1), 32'd1);
    lit_seen = (an != 4'b1111);
    if (rst) begin
      model_reset();
    end else begin
      if (at_wrap && pend) begin
        for (int i = 0; i < 4; i++) act_d[i] = sh_d[i];
        act_blank = sh_blank;
        act_dp    = sh_dp;
      end
      if (load) begin
        sh_d[0] = d0; sh_d[1] = d1; sh_d[2] = d2; sh_d[3] = d3;
        sh_blank = blank_mask;
        sh_dp    = dp_mask;
        pend     = 1'b1;
      end else if (at_wrap) begin
        pend = 1'b0;
      end
      k++;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Leaves the model so that the next tick is the frame-wrap edge.
  task automatic run_to_wrap();
    for (int i = 0; i < FRAME && (k % FRAME) != FRAME - 1; i++) tick();
  endtask

  task automatic do_load(input logic [3:0] a3, a2, a1, a0, bm, dm);
    d3 = a3; d2 = a2; d1 = a1; d0 = a0;
    blank_mask = bm;
    dp_mask    = dm;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic duty(input string tag, input logic [2:0] b);
    int cnt;
    bright = b;
    run(8);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (lit_seen) cnt++;
    end
    check(tag, 32'(cnt), 32'(b) + 32'd1);
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    run(3);
    rst = 1'b0;

    // Dark display and frame_done cadence with no load.
    run(3 * FRAME + 2);

    // F,8,1,0 pattern with decimal point on digit 2.
    run(3);
    do_load(4'hF, 4'h8, 4'h1, 4'h0, 4'b0000, 4'b0100);
    run_to_wrap();
    tick();
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < DIV; c++) begin
        tick();
        check("seq_an", 32'(an), 32'(AN_SEQ[s]));
        check("seq_seg", 32'(seg), 32'(SEG_SEQ[s]));
        check("seq_dp", 32'(dp), (s == 2) ? 32'd0 : 32'd1);
      end
    end
    run(FRAME);

    // Two loads within one frame: only the second is committed.
    run_to_wrap();
    run(5);
    do_load(4'h2, 4'h3, 4'h4, 4'h5, 4'b0001, 4'b1000);
    run(3);
    do_load(4'hA, 4'hB, 4'hC, 4'hD, 4'b0000, 4'b0011);
    run(2 * FRAME);

    // Load coincident with the wrap edge.
    run_to_wrap();
    do_load(4'h6, 4'h7, 4'h9, 4'hE, 4'b0010, 4'b0001);
    run(2 * FRAME + 3);

    // Brightness duty cycle with every digit lit.
    do_load(4'h1, 4'h2, 4'h3, 4'h4, 4'b0000, 4'b0000);
    run(2 * FRAME);
    duty("duty_b0", 3'd0);
    duty("duty_b3", 3'd3);
    duty("duty_b7", 3'd7);
    duty("duty_rand", 3'($urandom_range(0, 7)));
    bright = 3'd7;

    // Reset in slot 2 while a load is pending.
    run_to_wrap();
    tick();
    do_load(4'h5, 4'h5, 4'h5, 4'h5, 4'b0000, 4'b1111);
    for (int i = 0; i < FRAME && (k % FRAME) != 2 * DIV + 1; i++) tick();
    check("pend_before_rst", 32'(pend), 32'd1);
    rst = 1'b1;
    tick();
    check("dark_after_rst", 32'(an), 32'hF);
    rst = 1'b0;
    run(2 * FRAME + 4);
    do_load(4'h8, 4'h0, 4'hB, 4'h7, 4'b0100, 4'b0010);
    run(2 * FRAME);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      load = ($urandom_range(0, 11) == 0);
      d0 = 4'($urandom); d1 = 4'($urandom); d2 = 4'($urandom); d3 = 4'($urandom);
      blank_mask = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      dp_mask    = 4'($urandom);
      if (i % 50 == 0) bright = 3'($urandom);
      rst = ($urandom_range(0, 399) == 0);
      tick();
    end
    load = 1'b0;
    rst  = 1'b0;
    run(FRAME);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
